// File: rtl/branch_predictor_bht.sv
// PC-indexed table of saturating counters with optional gshare history.
// Lookup is a combinational read in Decode; the resolving branch updates the table in MEM.
module branch_predictor_bht #(
    parameter int IDX_BITS  = 6,
    parameter int CNT_BITS  = 2,
    parameter int HIST_BITS = 0,
    parameter int STAT_BITS = 32
) (
    input  logic                 clk_i,
    input  logic                 rstn_i,
    input  logic                 lookup_valid_i,
    input  logic [31:0]          lookup_pc_i,
    input  logic [31:0]          lookup_offset_i,
    output logic                 predict_o,
    output logic [31:0]          target_o,
    output logic [IDX_BITS-1:0]  lookup_idx_o,
    input  logic                 update_valid_i,
    input  logic [IDX_BITS-1:0]  update_idx_i,
    input  logic                 update_taken_i,
    input  logic                 update_predicted_i,
    output logic [STAT_BITS-1:0] branch_count_o,
    output logic [STAT_BITS-1:0] mispredict_count_o
);

    localparam int                DEPTH   = 1 << IDX_BITS;
    localparam logic [CNT_BITS-1:0] CNT_WNT = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);

    logic [CNT_BITS-1:0]  table_q [DEPTH];
    logic [CNT_BITS-1:0]  cnt_cur;
    logic [CNT_BITS-1:0]  cnt_d;
    logic [IDX_BITS-1:0]  hist_idx;
    logic [STAT_BITS-1:0] branch_cnt_q, branch_cnt_d;
    logic [STAT_BITS-1:0] mispred_cnt_q, mispred_cnt_d;
    logic                 unused_pc_bits;

    // Only the word-aligned index bits of the PC select an entry.
    assign unused_pc_bits = ^{lookup_pc_i[1:0], lookup_pc_i[31:IDX_BITS+2]};

    generate
        if (HIST_BITS > 0) begin : g_hist
            logic [HIST_BITS-1:0] ghr_q;
            logic [HIST_BITS-1:0] ghr_d;

            if (HIST_BITS == 1) begin : g_one
                assign ghr_d = update_taken_i;
            end else begin : g_shift
                assign ghr_d = {ghr_q[HIST_BITS-2:0], update_taken_i};
            end

            always_ff @(posedge clk_i) begin
                if (!rstn_i) begin
                    ghr_q <= '0;
                end else if (update_valid_i) begin
                    ghr_q <= ghr_d;
                end
            end

            assign hist_idx = IDX_BITS'(ghr_q);
        end else begin : g_bimodal
            assign hist_idx = '0;
        end
    endgenerate

    assign lookup_idx_o = lookup_pc_i[IDX_BITS+1:2] ^ hist_idx;
    assign target_o     = lookup_pc_i + lookup_offset_i;
    assign predict_o    = lookup_valid_i & table_q[lookup_idx_o][CNT_BITS-1];

    always_comb begin
        cnt_cur = table_q[update_idx_i];
        cnt_d   = cnt_cur;
        if (update_taken_i) begin
            if (cnt_cur != '1) cnt_d = cnt_cur + CNT_BITS'(1);
        end else begin
            if (cnt_cur != '0) cnt_d = cnt_cur - CNT_BITS'(1);
        end
    end

    // No bypass: a same-cycle lookup of the updated entry still sees the old value.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_q[i] <= CNT_WNT;
            end
        end else if (update_valid_i) begin
            table_q[update_idx_i] <= cnt_d;
        end
    end

    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (update_valid_i) begin
            if (branch_cnt_q != '1) branch_cnt_d = branch_cnt_q + STAT_BITS'(1);
            if ((update_predicted_i != update_taken_i) && (mispred_cnt_q != '1)) begin
                mispred_cnt_d = mispred_cnt_q + STAT_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign branch_count_o     = branch_cnt_q;
    assign mispredict_count_o = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Directed bench for branch_predictor_bht: default, gshare (IDX4/HIST3) and narrow-stat
// instances share one stimulus stream; each task checks its own scenario.
module tb_branch_predictor_bht;

    logic        clk = 1'b0;
    logic        rstn;
    logic        lv;
    logic [31:0] pc;
    logic [31:0] off;
    logic        uv;
    logic [5:0]  uidx;
    logic        ut;
    logic        up;

    logic        pred1, pred2, pred3;
    logic [31:0] tgt1, tgt2, tgt3;
    logic [5:0]  lidx1, lidx3;
    logic [3:0]  lidx2;
    logic [31:0] bc1, mc1, bc2, mc2;
    logic [3:0]  bc3, mc3;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    branch_predictor_bht dut1 (
        .clk_i(clk), .rstn_i(rstn),
        .lookup_valid_i(lv), .lookup_pc_i(pc), .lookup_offset_i(off),
        .predict_o(pred1), .target_o(tgt1), .lookup_idx_o(lidx1),
        .update_valid_i(uv), .update_idx_i(uidx), .update_taken_i(ut),
        .update_predicted_i(up),
        .branch_count_o(bc1), .mispredict_count_o(mc1)
    );

    branch_predictor_bht #(.IDX_BITS(4), .HIST_BITS(3)) dut2 (
        .clk_i(clk), .rstn_i(rstn),
        .lookup_valid_i(lv), .lookup_pc_i(pc), .lookup_offset_i(off),
        .predict_o(pred2), .target_o(tgt2), .lookup_idx_o(lidx2),
        .update_valid_i(uv), .update_idx_i(uidx[3:0]), .update_taken_i(ut),
        .update_predicted_i(up),
        .branch_count_o(bc2), .mispredict_count_o(mc2)
    );

    branch_predictor_bht #(.STAT_BITS(4)) dut3 (
        .clk_i(clk), .rstn_i(rstn),
        .lookup_valid_i(lv), .lookup_pc_i(pc), .lookup_offset_i(off),
        .predict_o(pred3), .target_o(tgt3), .lookup_idx_o(lidx3),
        .update_valid_i(uv), .update_idx_i(uidx), .update_taken_i(ut),
        .update_predicted_i(up),
        .branch_count_o(bc3), .mispredict_count_o(mc3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_update(input logic [5:0] idx, input logic taken, input logic predicted);
        uv   = 1'b1;
        uidx = idx;
        ut   = taken;
        up   = predicted;
        tick();
        uv   = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        lv = 1'b0; pc = 32'h0; off = 32'h0; uv = 1'b0; uidx = '0; ut = 1'b0; up = 1'b0;
        rstn = 1'b0;
        tick();
        tick();
        n_vec++;
        if (pred1 !== 1'b0) begin
            n_err++; $display("FAIL reset_predict got %b want 0", pred1);
        end
        rstn = 1'b1;
        lv = 1'b1; pc = 32'h100; off = 32'h20;
        #1;
        n_vec++;
        if (pred1 !== 1'b0) begin
            n_err++; $display("FAIL init_predict got %b want 0", pred1);
        end
        n_vec++;
        if (tgt1 !== 32'h120) begin
            n_err++; $display("FAIL init_target got %h want 00000120", tgt1);
        end
        n_vec++;
        if (lidx1 !== 6'd0 || lidx2 !== 4'd0) begin
            n_err++; $display("FAIL init_idx got %0d/%0d want 0/0", lidx1, lidx2);
        end
        n_vec++;
        if (bc1 !== 32'd0 || mc1 !== 32'd0 || bc3 !== 4'd0 || mc3 !== 4'd0) begin
            n_err++; $display("FAIL init_stats got %0d/%0d/%0d/%0d want 0/0/0/0", bc1, mc1, bc3, mc3);
        end
        $display("test_reset done: vectors=%0d miscompares=%0d", n_vec, n_err);
    endtask

    task automatic test_train();
        pc = 32'h100; lv = 1'b1;
        do_update(6'd0, 1'b1, 1'b0);
        n_vec++;
        if (pred1 !== 1'b1) begin
            n_err++; $display("FAIL train1_predict got %b want 1", pred1);
        end
        do_update(6'd0, 1'b1, 1'b0);
        n_vec++;
        if (pred1 !== 1'b1) begin
            n_err++; $display("FAIL train2_predict got %b want 1", pred1);
        end
        n_vec++;
        if (bc1 !== 32'd2 || mc1 !== 32'd2) begin
            n_err++; $display("FAIL train_stats got %0d/%0d want 2/2", bc1, mc1);
        end
        $display("test_train done: vectors=%0d miscompares=%0d", n_vec, n_err);
    endtask

    task automatic test_saturation();
        pc = 32'h100; lv = 1'b1;
        for (int i = 0; i < 3; i++) do_update(6'd0, 1'b1, 1'b1);
        lv = 1'b0;
        #1;
        n_vec++;
        if (pred1 !== 1'b0) begin
            n_err++; $display("FAIL novalid_predict got %b want 0", pred1);
        end
        lv = 1'b1;
        do_update(6'd0, 1'b0, 1'b1);
        n_vec++;
        if (pred1 !== 1'b1) begin
            n_err++; $display("FAIL sat_dec1_predict got %b want 1", pred1);
        end
        do_update(6'd0, 1'b0, 1'b1);
        n_vec++;
        if (pred1 !== 1'b0) begin
            n_err++; $display("FAIL sat_dec2_predict got %b want 0", pred1);
        end
        n_vec++;
        if (bc1 !== 32'd7 || mc1 !== 32'd4) begin
            n_err++; $display("FAIL sat_stats got %0d/%0d want 7/4", bc1, mc1);
        end
        $display("test_saturation done: vectors=%0d miscompares=%0d", n_vec, n_err);
    endtask

    task automatic test_gshare();
        logic [3:0] exp_ghr [3];
        logic       taken   [3];
        exp_ghr[0] = 4'b0001; exp_ghr[1] = 4'b0011; exp_ghr[2] = 4'b0110;
        taken[0] = 1'b1; taken[1] = 1'b1; taken[2] = 1'b0;
        do_reset();
        lv = 1'b1; pc = 32'h0;
        for (int i = 0; i < 3; i++) begin
            do_update(6'd0, taken[i], 1'b0);
            n_vec++;
            if (lidx2 !== exp_ghr[i]) begin
                n_err++; $display("FAIL ghr_step%0d got %b want %b", i, lidx2, exp_ghr[i]);
            end
        end
        pc = 32'h14;
        #1;
        n_vec++;
        if (lidx2 !== 4'b0011) begin
            n_err++; $display("FAIL gshare_idx got %b want 0011", lidx2);
        end
        n_vec++;
        if (lidx1 !== 6'd5) begin
            n_err++; $display("FAIL bimodal_idx got %0d want 5", lidx1);
        end
        $display("test_gshare done: vectors=%0d miscompares=%0d", n_vec, n_err);
    endtask

    task automatic test_same_cycle();
        do_reset();
        lv = 1'b1; pc = 32'h1C;
        uv = 1'b1; uidx = 6'd7; ut = 1'b1; up = 1'b0;
        #1;
        n_vec++;
        if (pred1 !== 1'b0) begin
            n_err++; $display("FAIL same_cycle_predict got %b want 0", pred1);
        end
        tick();
        uv = 1'b0;
        #1;
        n_vec++;
        if (pred1 !== 1'b1) begin
            n_err++; $display("FAIL next_cycle_predict got %b want 1", pred1);
        end
        $display("test_same_cycle done: vectors=%0d miscompares=%0d", n_vec, n_err);
    endtask

    task automatic test_stat_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) do_update(6'd3, 1'b1, 1'b0);
        n_vec++;
        if (mc3 !== 4'd15 || bc3 !== 4'd15) begin
            n_err++; $display("FAIL stat4_sat got %0d/%0d want 15/15", bc3, mc3);
        end
        n_vec++;
        if (bc1 !== 32'd20 || mc1 !== 32'd20) begin
            n_err++; $display("FAIL stat32_count got %0d/%0d want 20/20", bc1, mc1);
        end
        rstn = 1'b0;
        uv = 1'b1; uidx = 6'd3; ut = 1'b1; up = 1'b0;
        tick();
        rstn = 1'b1; uv = 1'b0;
        lv = 1'b1; pc = 32'hC;
        #1;
        n_vec++;
        if (bc3 !== 4'd0 || mc3 !== 4'd0 || bc1 !== 32'd0 || mc1 !== 32'd0) begin
            n_err++; $display("FAIL reset_stats got %0d/%0d/%0d/%0d want 0/0/0/0", bc3, mc3, bc1, mc1);
        end
        n_vec++;
        if (pred1 !== 1'b0) begin
            n_err++; $display("FAIL reset_table got %b want 0", pred1);
        end
        pc = 32'h14;
        #1;
        n_vec++;
        if (lidx2 !== 4'b0101) begin
            n_err++; $display("FAIL reset_ghr_idx got %b want 0101", lidx2);
        end
        pc = 32'hC;
        do_update(6'd3, 1'b1, 1'b0);
        n_vec++;
        if (pred1 !== 1'b1) begin
            n_err++; $display("FAIL reset_wnt_inc got %b want 1", pred1);
        end
        $display("test_stat_saturation done: vectors=%0d miscompares=%0d", n_vec, n_err);
    endtask

    initial begin
        test_reset();
        test_train();
        test_saturation();
        test_gshare();
        test_same_cycle();
        test_stat_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
